usrt_rx_buffer: RTL and testbench

Receive-side buffer between the USRT deserializer and the APB read register.
- Takes each 11-bit frame captured by the deserializer and checks start, stop and parity bits.
- Stores the payload in a small FIFO for the APB side to drain.
- Keeps sticky error flags and drives a fill-level interrupt, so software no longer loses bytes when reads are slower than the line rate.

---
 rtl/usrt_rx_buffer_pkg.sv | 22 ++
 rtl/usrt_frame_check.sv | 21 ++
 rtl/usrt_rx_buffer.sv | 111 +++++++++++
 tb/tb_usrt_rx_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usrt_rx_buffer_pkg.sv
// Shared USRT definitions: frame layout and the buffered receive entry.
// Also used by the deserializer and serializer.
package usrt_rx_buffer_pkg;

   localparam int unsigned FRAME_W    = 11;
   localparam int unsigned START_BIT  = 0;
   localparam int unsigned DATA_LSB   = 1;
   localparam int unsigned DATA_MSB   = 8;
   localparam int unsigned PARITY_BIT = 9;
   localparam int unsigned STOP_BIT   = 10;
   localparam int unsigned DATA_W     = DATA_MSB - DATA_LSB + 1;

   typedef struct packed {
      logic              perr;
      logic [DATA_W-1:0] data;
   } rx_entry_t;

   function automatic logic framing_ok(input logic [FRAME_W-1:0] f);
      return (f[START_BIT] == 1'b0) && (f[STOP_BIT] == 1'b1);
   endfunction

endpackage

// File: rtl/usrt_frame_check.sv
// Combinational frame decode: payload, parity error and framing error.
// Kept separate so loopback checks can reuse it.
module usrt_frame_check
   import usrt_rx_buffer_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic [FRAME_W-1:0] frame,
   output logic [DATA_W-1:0]  data,
   output logic               perr,
   output logic               ferr
);

   always_comb begin
      data = frame[DATA_MSB:DATA_LSB];
      // Parity bit is covered by the reduction, so the result must equal PARITY_ODD.
      perr = (^frame[PARITY_BIT:DATA_LSB]) != PARITY_ODD;
      ferr = !framing_ok(frame);
   end

endmodule

// File: rtl/usrt_rx_buffer.sv
// Receive buffer: validates deserialized frames, queues payloads for APB reads,
// and keeps sticky overrun/framing flags plus a fill-level interrupt.
module usrt_rx_buffer
   import usrt_rx_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter bit          PARITY_ODD = 1'b0,
   parameter int unsigned IRQ_LEVEL  = 1
) (
   input  logic                    pClk,
   input  logic                    pReset,
   input  logic [FRAME_W-1:0]      frame,
   input  logic                    frame_valid,
   input  logic                    pop,
   input  logic                    clr_err,
   output logic [DATA_W-1:0]       rData,
   output logic                    rPerr,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overrun_err,
   output logic                    frame_err,
   output logic                    rx_irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] IRQ_C   = CW'(IRQ_LEVEL);

   rx_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovr_q, ovr_d;
   logic              ferr_q, ferr_d;

   logic [DATA_W-1:0] chk_data;
   logic              chk_perr;
   logic              chk_ferr;
   logic              push, pop_ok, drop;
   rx_entry_t         wr_entry;
   rx_entry_t         head;

   usrt_frame_check #(
      .PARITY_ODD(PARITY_ODD)
   ) u_frame_check (
      .frame (frame),
      .data  (chk_data),
      .perr  (chk_perr),
      .ferr  (chk_ferr)
   );

   always_comb begin
      pop_ok = pop && (count_q != '0);
      // A same-cycle pop frees the slot, so a full FIFO still accepts the frame.
      push   = frame_valid && !chk_ferr && ((count_q != DEPTH_C) || pop_ok);
      drop   = frame_valid && !chk_ferr && (count_q == DEPTH_C) && !pop;

      wr_entry.perr = chk_perr;
      wr_entry.data = chk_data;

      wptr_d = push   ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop_ok ? rptr_q + 1'b1 : rptr_q;

      count_d = count_q;
      if (push && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push) begin
         count_d = count_q - 1'b1;
      end

      ovr_d  = drop                      ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
      ferr_d = (frame_valid && chk_ferr) ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
   end

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_ff @(posedge pClk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_entry;
      end
   end

   always_comb begin
      head        = mem_q[rptr_q];
      empty       = (count_q == '0);
      full        = (count_q == DEPTH_C);
      rx_irq      = (count_q >= IRQ_C);
      count       = count_q;
      rData       = empty ? '0 : head.data;
      rPerr       = !empty && head.perr;
      overrun_err = ovr_q;
      frame_err   = ferr_q;
   end

endmodule

// File: tb/tb_usrt_rx_buffer.sv
// Self-checking bench for usrt_rx_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_usrt_rx_buffer;

   localparam int unsigned DEPTH = 4;

   logic        pClk = 1'b0;
   logic        pReset;
   logic [10:0] frame;
   logic        frame_valid, pop, clr_err;
   logic [7:0]  rData;
   logic        rPerr, empty, full;
   logic [2:0]  count;
   logic        overrun_err, frame_err, rx_irq;

   logic [10:0] o_frame;
   logic        o_valid, o_pop, o_clr;
   logic [7:0]  o_rData;
   logic        o_rPerr, o_empty, o_full;
   logic [2:0]  o_count;
   logic        o_ovr, o_ferr, o_irq;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [8:0] mq[$];
   bit         m_ovr, m_ferr;

   always #5 pClk = ~pClk;

   usrt_rx_buffer #(.DEPTH(DEPTH), .PARITY_ODD(1'b0), .IRQ_LEVEL(1)) dut (
      .pClk(pClk), .pReset(pReset), .frame(frame), .frame_valid(frame_valid),
      .pop(pop), .clr_err(clr_err), .rData(rData), .rPerr(rPerr), .empty(empty),
      .full(full), .count(count), .overrun_err(overrun_err), .frame_err(frame_err),
      .rx_irq(rx_irq));

   usrt_rx_buffer #(.DEPTH(DEPTH), .PARITY_ODD(1'b1), .IRQ_LEVEL(3)) dut_odd (
      .pClk(pClk), .pReset(pReset), .frame(o_frame), .frame_valid(o_valid),
      .pop(o_pop), .clr_err(o_clr), .rData(o_rData), .rPerr(o_rPerr), .empty(o_empty),
      .full(o_full), .count(o_count), .overrun_err(o_ovr), .frame_err(o_ferr),
      .rx_irq(o_irq));

   // Good framing; even parity correct unless bad_par is set.
   function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par);
      return {1'b1, (^d) ^ bad_par, d, 1'b0};
   endfunction

   // Drive one cycle on the even-parity DUT and advance the reference model.
   task automatic step(input logic [10:0] f, input bit v, input bit p, input bit c);
      bit good, set_ovr;
      frame = f; frame_valid = v; pop = p; clr_err = c;
      good    = (f[0] == 1'b0) && (f[10] == 1'b1);
      set_ovr = v && good && (mq.size() == DEPTH) && !p;
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (v && good && mq.size() < DEPTH) mq.push_back({^f[9:1], f[8:1]});
      m_ovr  = set_ovr      ? 1'b1 : (c ? 1'b0 : m_ovr);
      m_ferr = (v && !good) ? 1'b1 : (c ? 1'b0 : m_ferr);
      @(posedge pClk); #1;
      frame = '0; frame_valid = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full); end
      n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
      n_cmp++; if (rData !== 8'h00 || rPerr !== 1'b0) begin n_fail++; $display("FAIL reset_head got=%h/%b want=00/0", rData, rPerr); end
      n_cmp++; if ({overrun_err, frame_err, rx_irq} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b want=000", {overrun_err, frame_err, rx_irq}); end
      @(negedge pClk); pReset = 1'b1;
      @(posedge pClk); #1;
   endtask

   task automatic test_single();
      step(11'b1_0_01010101_0, 1, 0, 0);
      n_cmp++; if (empty !== 1'b0 || count !== 3'd1) begin n_fail++; $display("FAIL single_level got=%b/%0d want=0/1", empty, count); end
      n_cmp++; if (rData !== 8'h55 || rPerr !== 1'b0) begin n_fail++; $display("FAIL single_head got=%h/%b want=55/0", rData, rPerr); end
      n_cmp++; if (rx_irq !== 1'b1) begin n_fail++; $display("FAIL single_irq got=%b want=1", rx_irq); end
      step('0, 0, 1, 0);
      n_cmp++; if (empty !== 1'b1 || rData !== 8'h00 || rx_irq !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b/%h/%b want=1/00/0", empty, rData, rx_irq); end
      step('0, 0, 1, 0);
      n_cmp++; if (count !== 3'd0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL pop_empty got=%0d/%b want=0/0", count, overrun_err); end
   endtask

   task automatic test_fill_overrun();
      logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) step(mk(vals[i], 0), 1, 0, 0);
      n_cmp++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fill_full got=%b/%0d want=1/4", full, count); end
      step(mk(8'h99, 0), 1, 0, 0);
      n_cmp++; if (overrun_err !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL overrun got=%b/%0d want=1/4", overrun_err, count); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rData !== vals[i]) begin n_fail++; $display("FAIL fifo_order[%0d] got=%h want=%h", i, rData, vals[i]); end
         step('0, 0, 1, 0);
      end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty got=%b want=1", empty); end
      step('0, 0, 0, 1);
      n_cmp++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b want=0", overrun_err); end
   endtask

   task automatic test_frame_err();
      logic [10:0] f;
      step(mk(8'h5A, 0), 1, 0, 0);
      f = mk(8'h3C, 0); f[10] = 1'b0;
      step(f, 1, 0, 0);
      n_cmp++; if (frame_err !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL stop_bad got=%b/%0d want=1/1", frame_err, count); end
      step('0, 0, 0, 1);
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got=%b want=0", frame_err); end
      f = mk(8'h3C, 0); f[0] = 1'b1;
      step(f, 1, 0, 0);
      n_cmp++; if (frame_err !== 1'b1 || count !== 3'd1 || rData !== 8'h5A) begin n_fail++; $display("FAIL start_bad got=%b/%0d/%h want=1/1/5a", frame_err, count, rData); end
      step('0, 0, 0, 1);
      step(f, 1, 0, 1);
      n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b want=1", frame_err); end
      step('0, 0, 1, 1);
      n_cmp++; if (frame_err !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL ferr_end got=%b/%b want=0/1", frame_err, empty); end
   endtask

   task automatic test_parity();
      step(mk(8'h01, 1), 1, 0, 0);
      step(mk(8'h02, 0), 1, 0, 0);
      n_cmp++; if (rData !== 8'h01 || rPerr !== 1'b1) begin n_fail++; $display("FAIL perr_even got=%h/%b want=01/1", rData, rPerr); end
      step('0, 0, 1, 0);
      n_cmp++; if (rData !== 8'h02 || rPerr !== 1'b0) begin n_fail++; $display("FAIL perr_next got=%h/%b want=02/0", rData, rPerr); end
      step('0, 0, 1, 0);
      o_frame = mk(8'h01, 1); o_valid = 1'b1;
      @(posedge pClk); #1;
      n_cmp++; if (o_rData !== 8'h01 || o_rPerr !== 1'b0) begin n_fail++; $display("FAIL perr_odd got=%h/%b want=01/0", o_rData, o_rPerr); end
      o_frame = mk(8'h07, 0);
      @(posedge pClk); #1;
      n_cmp++; if (o_count !== 3'd2 || o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_below got=%0d/%b want=2/0", o_count, o_irq); end
      @(posedge pClk); #1;
      o_valid = 1'b0;
      n_cmp++; if (o_irq !== 1'b1 || o_full !== 1'b0) begin n_fail++; $display("FAIL irq_at_level got=%b/%b want=1/0", o_irq, o_full); end
      o_pop = 1'b1;
      @(posedge pClk); #1;
      n_cmp++; if (o_rPerr !== 1'b1 || o_rData !== 8'h07) begin n_fail++; $display("FAIL perr_odd_bad got=%h/%b want=07/1", o_rData, o_rPerr); end
      repeat (2) @(posedge pClk); #1;
      o_pop = 1'b0;
      n_cmp++; if ({o_empty, o_ovr, o_ferr, o_irq} !== 4'b1000) begin n_fail++; $display("FAIL odd_drain got=%b want=1000", {o_empty, o_ovr, o_ferr, o_irq}); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
      for (int i = 0; i < 4; i++) step(mk(8'hA0 + 8'(i), 0), 1, 0, 0);
      step(mk(8'hB0, 0), 1, 1, 0);
      n_cmp++; if (overrun_err !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop got=%b/%0d want=0/4", overrun_err, count); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rData !== exp[i]) begin n_fail++; $display("FAIL full_pushpop_order[%0d] got=%h want=%h", i, rData, exp[i]); end
         step('0, 0, 1, 0);
      end
      step(mk(8'hC0, 0), 1, 1, 0);
      n_cmp++; if (count !== 3'd1 || rData !== 8'hC0) begin n_fail++; $display("FAIL empty_pushpop got=%0d/%h want=1/c0", count, rData); end
      step('0, 0, 1, 0);
   endtask

   task automatic test_random();
      logic [10:0] f;
      logic [16:0] got, exp;
      bit v, p, c;
      for (int i = 0; i < 400; i++) begin
         f = mk(8'($urandom), $urandom_range(3) == 0);
         if ($urandom_range(7) == 0) begin
            if ($urandom_range(1) == 0) f[0] = 1'b1; else f[10] = 1'b0;
         end
         v = $urandom_range(99) < 60;
         p = $urandom_range(99) < (((i / 50) % 2) ? 75 : 25);
         c = $urandom_range(15) == 0;
         step(f, v, p, c);
         exp = {(mq.size() > 0) ? mq[0][7:0] : 8'h00, (mq.size() > 0) ? mq[0][8] : 1'b0,
                3'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_ovr, m_ferr, mq.size() >= 1};
         got = {rData, rPerr, count, empty, full, overrun_err, frame_err, rx_irq};
         n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, got, exp); end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i <= DEPTH; i++) step('0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(mk(8'h60 + 8'(i), 0), 1, 0, 0);
      step(11'h000, 1, 0, 0);
      n_cmp++; if (count !== 3'd3 || frame_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%0d/%b want=3/1", count, frame_err); end
      #2 pReset = 1'b0;
      #1;
      n_cmp++; if (empty !== 1'b1 || count !== 3'd0 || rData !== 8'h00) begin n_fail++; $display("FAIL async_reset got=%b/%0d/%h want=1/0/00", empty, count, rData); end
      n_cmp++; if ({overrun_err, frame_err, rx_irq} !== 3'b000) begin n_fail++; $display("FAIL async_flags got=%b want=000", {overrun_err, frame_err, rx_irq}); end
      mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
      @(negedge pClk); pReset = 1'b1;
      @(posedge pClk); #1;
      step(mk(8'hA5, 0), 1, 0, 0);
      n_cmp++; if (rData !== 8'hA5 || count !== 3'd1 || rPerr !== 1'b0) begin n_fail++; $display("FAIL post_reset got=%h/%0d/%b want=a5/1/0", rData, count, rPerr); end
   endtask

   initial begin
      pReset = 1'b0;
      frame = '0; frame_valid = 1'b0; pop = 1'b0; clr_err = 1'b0;
      o_frame = '0; o_valid = 1'b0; o_pop = 1'b0; o_clr = 1'b0;
      m_ovr = 1'b0; m_ferr = 1'b0;
      test_reset();
      test_single();
      test_fill_overrun();
      test_frame_err();
      test_parity();
      test_simultaneous();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
